// File: rtl/vend_dispense_controller.sv
// Vending sequencer: accumulates coin credit in quarters, requests a guffin at
// price, and pays change or refunds one coin at a time over a four-phase req/ack.
module vend_dispense_controller #(
    parameter int unsigned PRICE_Q     = 6,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       quarter_in,
    input  logic       halfDollar_in,
    input  logic       dollar_in,
    input  logic       cancel_in,
    input  logic       disp_ack,
    output logic       guffin,
    output logic       quarter_out,
    output logic       halfDollar_out,
    output logic [3:0] credit,
    output logic       coin_reject,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state_code
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_VEND     = 3'd2,
        S_CHANGE   = 3'd3,
        S_WAIT_REL = 3'd4,
        S_FAULT    = 3'd7
    } state_t;

    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_V = CW'(ACK_TIMEOUT);
    localparam logic [4:0]    PRICE_V   = 5'(PRICE_Q);

    state_t        state, state_next;
    logic [3:0]    credit_next;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic          reject_next, fault_next;
    logic [1:0]    coin_cnt;
    logic [2:0]    coin_val;
    logic [4:0]    sum;
    logic          any_coin, multi_coin;

    always_comb begin
        coin_cnt   = {1'b0, quarter_in} + {1'b0, halfDollar_in} + {1'b0, dollar_in};
        any_coin   = (coin_cnt != 2'd0);
        multi_coin = (coin_cnt > 2'd1);
        unique case ({dollar_in, halfDollar_in, quarter_in})
            3'b001:  coin_val = 3'd1;
            3'b010:  coin_val = 3'd2;
            3'b100:  coin_val = 3'd4;
            default: coin_val = 3'd0;
        endcase
        sum     = {1'b0, credit} + {2'b00, coin_val};
        cnt_inc = cnt + 1'b1;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        credit_next = credit;
        cnt_next    = cnt;
        reject_next = 1'b0;
        fault_next  = fault;

        unique case (state)
            S_IDLE, S_COLLECT: begin
                if (any_coin && (multi_coin || cancel_in)) begin
                    reject_next = 1'b1;
                end else if (any_coin) begin
                    if (sum < PRICE_V) begin
                        credit_next = sum[3:0];
                        state_next  = S_COLLECT;
                    end else begin
                        credit_next = 4'(sum - PRICE_V);
                        state_next  = S_VEND;
                        cnt_next    = '0;
                    end
                end
                if (cancel_in && state == S_COLLECT) begin
                    state_next = S_CHANGE;
                    cnt_next   = '0;
                end
            end

            S_VEND, S_CHANGE: begin
                reject_next = any_coin;
                if (disp_ack) begin
                    state_next = S_WAIT_REL;
                    if (state == S_CHANGE)
                        credit_next = (credit >= 4'd2) ? credit - 4'd2 : credit - 4'd1;
                end else if (cnt_inc == TIMEOUT_V) begin
                    state_next = S_FAULT;
                    fault_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            S_WAIT_REL: begin
                reject_next = any_coin;
                if (!disp_ack) begin
                    if (credit != 4'd0) begin
                        state_next = S_CHANGE;
                        cnt_next   = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end

            S_FAULT: reject_next = any_coin;

            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state          <= S_IDLE;
            credit         <= 4'd0;
            cnt            <= '0;
            coin_reject    <= 1'b0;
            fault          <= 1'b0;
            guffin         <= 1'b0;
            quarter_out    <= 1'b0;
            halfDollar_out <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            credit         <= credit_next;
            cnt            <= cnt_next;
            coin_reject    <= reject_next;
            fault          <= fault_next;
            // Requests are decoded from the next state so they rise on the entry edge.
            guffin         <= (state_next == S_VEND);
            halfDollar_out <= (state_next == S_CHANGE) && (credit_next >= 4'd2);
            quarter_out    <= (state_next == S_CHANGE) && (credit_next == 4'd1);
            busy           <= (state_next == S_VEND) || (state_next == S_CHANGE) ||
                              (state_next == S_WAIT_REL);
        end
    end

    assign state_code = state;

endmodule
